// File: rtl/spi_bridge_if.sv
// Pad-side SPI pins and decoder-side byte bundle for spi_bridge.
// The bridge takes the slave modport; pads/decoder use master.
interface spi_bridge_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       frame_active;

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        input  data_out,
        output miso,
        output byte_sync,
        output data_in,
        output frame_active
    );

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        output data_out,
        input  miso,
        input  byte_sync,
        input  data_in,
        input  frame_active
    );
endinterface

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end, oversampled in the clk domain.
// Emits one byte_sync per received byte and shifts data_out onto miso.
module spi_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_bridge_if.slave bus
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   hist_sclk;
    logic                   armed;

    logic       sync_sclk;
    logic       sync_cs;
    logic       sync_mosi;
    logic       rise;
    logic       fall;
    logic       active;

    logic [2:0] bit_cnt;
    logic [7:0] rx_sh;
    logic [7:0] tx_sh;
    logic       done;
    logic       miso_q;
    logic       sync_q;
    logic [7:0] data_q;

    assign sync_sclk = sclk_q[SYNC_STAGES-1];
    assign sync_cs   = cs_q[SYNC_STAGES-1];
    assign sync_mosi = mosi_q[SYNC_STAGES-1];

    assign rise = sync_sclk & ~hist_sclk;
    assign fall = ~sync_sclk & hist_sclk;

    // Not armed until cs_n is seen high, so a frame in flight at reset release is ignored.
    assign active = armed & ~sync_cs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q    <= '0;
            cs_q      <= '0;
            mosi_q    <= '0;
            hist_sclk <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
            cs_q      <= {cs_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            hist_sclk <= sync_sclk;
            if (sync_cs) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
            done    <= 1'b0;
            miso_q  <= 1'b0;
            sync_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            done   <= 1'b0;
            sync_q <= done;
            if (done) begin
                data_q <= rx_sh;
            end
            if (!active) begin
                bit_cnt <= 3'd0;
                rx_sh   <= 8'h00;
                tx_sh   <= 8'h00;
                miso_q  <= 1'b0;
            end else begin
                if (rise) begin
                    rx_sh   <= {rx_sh[6:0], sync_mosi};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        done <= 1'b1;
                    end
                end
                // Byte boundary reloads from the decoder; otherwise keep shifting.
                if (fall) begin
                    if (bit_cnt == 3'd0) begin
                        miso_q <= bus.data_out[7];
                        tx_sh  <= {bus.data_out[6:0], 1'b0};
                    end else begin
                        miso_q <= tx_sh[7];
                        tx_sh  <= {tx_sh[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.miso         = miso_q;
    assign bus.byte_sync    = sync_q;
    assign bus.data_in      = data_q;
    assign bus.frame_active = active;

endmodule

// File: tb/tb_spi_bridge.sv
// Self-checking bench for spi_bridge: SPI master, decoder model and
// a byte-level scoreboard checked every clk cycle.
module tb_spi_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_bridge_if bus();

    spi_bridge #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;
    int hp = 4;
    int cyc = 0;
    int cs_hi_cnt = 0;
    logic prev_bs = 1'b0;
    logic [7:0] model_last = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] got_q[$];
    int pulse_t[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Decoder model: answers each received byte with byte ^ 0xA2 two cycles later.
    initial begin
        logic [7:0] v;
        bus.data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus.byte_sync) begin
                v = bus.data_in ^ 8'hA2;
                @(posedge clk);
                @(posedge clk);
                #1 bus.data_out = v;
            end
        end
    end

    // Per-cycle scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_last = 8'h00;
            check("rst_miso", {31'd0, bus.miso}, 32'd0);
            check("rst_byte_sync", {31'd0, bus.byte_sync}, 32'd0);
            check("rst_data_in", {24'd0, bus.data_in}, 32'd0);
            check("rst_frame_active", {31'd0, bus.frame_active}, 32'd0);
        end else begin
            if (bus.byte_sync) begin
                check("strobe_width", {31'd0, prev_bs}, 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL spurious_strobe: got byte_sync=1 want 0");
                end else begin
                    model_last = exp_q.pop_front();
                end
                pulse_t.push_back(cyc);
            end
            check("data_in", {24'd0, bus.data_in}, {24'd0, model_last});
            if (cs_hi_cnt > 4) begin
                check("miso_idle", {31'd0, bus.miso}, 32'd0);
            end
        end
        prev_bs = bus.byte_sync;
        if (bus.cs_n) cs_hi_cnt++;
        else cs_hi_cnt = 0;
    end

    task automatic xfer_byte(input logic [7:0] tx, input int nbits,
                             input bit push, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            wait_clk(hp);
            got = {got[6:0], bus.miso};
            bus.sclk = 1'b1;
            if (push && i == 7) exp_q.push_back(tx);
            wait_clk(hp);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic run_frame();
        logic [7:0] got;
        logic [7:0] em;
        got_q.delete();
        bus.cs_n = 1'b0;
        wait_clk(4);
        check("frame_active_on", {31'd0, bus.frame_active}, 32'd1);
        for (int i = 0; i < fq.size(); i++) begin
            em = (i == 0) ? 8'h00 : (fq[i-1] ^ 8'hA2);
            xfer_byte(fq[i], 8, 1'b1, got);
            got_q.push_back(got);
            check("miso_byte", {24'd0, got}, {24'd0, em});
        end
        wait_clk(hp);
        bus.cs_n = 1'b1;
        wait_clk(8);
        check("frame_active_off", {31'd0, bus.frame_active}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g;
        int n;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(8);

        // Write frame.
        pulse_t.delete();
        fq = '{8'h85, 8'h3C};
        run_frame();
        check("wr_pulses", pulse_t.size(), 2);
        check("wr_last", {24'd0, bus.data_in}, 32'h3C);
        check("wr_first_miso", {24'd0, got_q[0]}, 32'h00);

        // Read frame: 0x05 answered with 0xA7.
        fq = '{8'h05, 8'h00};
        run_frame();
        check("rd_miso", {24'd0, got_q[1]}, 32'hA7);

        // Back-to-back at clk/8.
        hp = 4;
        pulse_t.delete();
        fq = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame();
        check("b2b_pulses", pulse_t.size(), 4);
        for (int i = 1; i < 4; i++) begin
            if (i < pulse_t.size())
                check("b2b_spacing", pulse_t[i] - pulse_t[i-1], 64);
        end

        // Abort after 5 bits.
        bus.cs_n = 1'b0;
        wait_clk(4);
        xfer_byte(8'hFF, 5, 1'b0, g);
        wait_clk(hp);
        bus.cs_n = 1'b1;
        wait_clk(10);
        check("abort_hold", {24'd0, bus.data_in}, 32'h04);
        fq = '{8'h42};
        run_frame();
        check("after_abort", {24'd0, bus.data_in}, 32'h42);

        // Reset mid-byte; frame still in progress at release is ignored.
        bus.cs_n = 1'b0;
        wait_clk(4);
        xfer_byte(8'h9E, 3, 1'b0, g);
        rst_n = 1'b0;
        wait_clk(3);
        check("midrst_data_in", {24'd0, bus.data_in}, 32'h00);
        check("midrst_miso", {31'd0, bus.miso}, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        wait_clk(2);
        xfer_byte(8'hFF, 8, 1'b0, g);
        wait_clk(hp);
        check("stale_frame", {24'd0, bus.data_in}, 32'h00);
        bus.cs_n = 1'b1;
        wait_clk(8);
        pulse_t.delete();
        fq = '{8'h9E};
        run_frame();
        check("rst_pulses", pulse_t.size(), 1);
        check("rst_byte", {24'd0, bus.data_in}, 32'h9E);

        // sclk toggling while deselected.
        pulse_t.delete();
        for (int i = 0; i < 8; i++) begin
            bus.mosi = i[0];
            wait_clk(4);
            bus.sclk = 1'b1;
            wait_clk(4);
            bus.sclk = 1'b0;
        end
        wait_clk(6);
        check("desel_pulses", pulse_t.size(), 0);
        check("desel_bit_cnt", {29'd0, dut.bit_cnt}, 32'd0);
        check("desel_miso", {31'd0, bus.miso}, 32'd0);

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            hp = $urandom_range(7, 4);
            n = $urandom_range(4, 1);
            fq.delete();
            for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
            pulse_t.delete();
            run_frame();
            check("rnd_pulses", pulse_t.size(), n);
        end
        wait_clk(10);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
